// File: rtl/edge_pulse_pkg.sv
// edge_pulse_pkg: per-channel edge-select encodings shared by the edge pulse blocks
package edge_pulse_pkg;
  typedef logic [1:0] edge_mode_t;
  localparam edge_mode_t EDGE_OFF  = 2'b00;
  localparam edge_mode_t EDGE_RISE = 2'b01;
  localparam edge_mode_t EDGE_FALL = 2'b10;
  localparam edge_mode_t EDGE_BOTH = 2'b11;
endpackage

// File: rtl/edge_pulse_channel.sv
// edge_pulse_channel: sync, debounce, edge-detect, pulse-stretch and sticky flag for one input
module edge_pulse_channel
  import edge_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int PULSE_WIDTH     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sig,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       pulse,
  output logic       level,
  output logic       flag
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PULSE_WIDTH + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] P_LOAD  = PW'(PULSE_WIDTH);
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic s, prev, qual;
  assign s     = sync[SYNC_STAGES-1];
  assign qual  = (mode[0] & level & ~prev) | (mode[1] & ~level & prev);
  assign pulse = pcnt != '0;
  // a new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      level <= 1'b0;
      dcnt  <= '0;
      prev  <= 1'b0;
      pcnt  <= '0;
      flag  <= 1'b0;
    end else begin
      sync  <= SYNC_STAGES'({sync, sig});
      level <= (s != level && dcnt == DB_LAST) ? s : level;
      dcnt  <= (s == level || dcnt == DB_LAST) ? '0 : dcnt + 1'b1;
      prev  <= level;
      pcnt  <= qual ? P_LOAD : pcnt - PW'(pulse);
      flag  <= qual | (flag & ~clr);
    end
endmodule

// File: rtl/edge_pulse_multi.sv
// edge_pulse_multi: N_CH independent level-to-pulse channels with selectable edge and sticky flag
module edge_pulse_multi
  import edge_pulse_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1,
  parameter int PULSE_WIDTH     = 1
) (
  input  logic              CLK,
  input  logic              Reset_N,
  input  logic [N_CH-1:0]   Signal_In,
  input  logic [2*N_CH-1:0] Edge_Mode,
  input  logic [N_CH-1:0]   Event_Clear,
  output logic [N_CH-1:0]   Pulse_Signal,
  output logic [N_CH-1:0]   Level_Out,
  output logic [N_CH-1:0]   Event_Flag
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_pulse_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .PULSE_WIDTH(PULSE_WIDTH)
    ) u_ch (
      .clk(CLK),
      .rst_n(Reset_N),
      .sig(Signal_In[i]),
      .mode(edge_mode_t'(Edge_Mode[2*i+:2])),
      .clr(Event_Clear[i]),
      .pulse(Pulse_Signal[i]),
      .level(Level_Out[i]),
      .flag(Event_Flag[i])
    );
  end
endmodule

// File: tb/tb_edge_pulse_multi.sv
// tb_edge_pulse_multi: directed literal checks plus randomized run against a window/elapsed-time model
module tb_edge_pulse_multi;
  localparam int N  = 4;
  localparam int S  = 2;
  localparam int D  = 3;
  localparam int PW = 3;
  logic CLK = 1'b0;
  logic Reset_N = 1'b0;
  logic [N-1:0] Signal_In = '0;
  logic [2*N-1:0] Edge_Mode = '0;
  logic [N-1:0] Event_Clear = '0;
  logic [N-1:0] Pulse_Signal, Level_Out, Event_Flag;
  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] rawh [N];
  logic st [N];
  logic pv [N];
  int since [N];
  logic flg [N];

  edge_pulse_multi #(.N_CH(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .PULSE_WIDTH(PW)) dut (
    .CLK(CLK), .Reset_N(Reset_N), .Signal_In(Signal_In), .Edge_Mode(Edge_Mode),
    .Event_Clear(Event_Clear), .Pulse_Signal(Pulse_Signal), .Level_Out(Level_Out),
    .Event_Flag(Event_Flag)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // model: level flips once the last D synchronised samples all disagree with it;
  // pulse is high while fewer than PW edges have elapsed since the last qualified edge
  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      logic flip, qual;
      if (!Reset_N) begin
        rawh[c] = '0; st[c] = 1'b0; pv[c] = 1'b0; since[c] = PW; flg[c] = 1'b0;
      end else begin
        flip = 1'b1;
        for (int j = 0; j < D; j++) if (rawh[c][S-1+j] == st[c]) flip = 1'b0;
        qual = (st[c] != pv[c]) && (st[c] ? Edge_Mode[2*c] : Edge_Mode[2*c+1]);
        pv[c] = st[c];
        if (flip) st[c] = ~st[c];
        since[c] = qual ? 0 : (since[c] < PW ? since[c] + 1 : PW);
        flg[c] = qual | (flg[c] & ~Event_Clear[c]);
        rawh[c] = {rawh[c][62:0], Signal_In[c]};
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge Reset_N);
    model_step();
  end

  always @(negedge CLK) begin
    logic [N-1:0] ep, el, ef;
    for (int c = 0; c < N; c++) begin
      ep[c] = since[c] < PW;
      el[c] = st[c];
      ef[c] = flg[c];
    end
    chk("model_pulse", Pulse_Signal, ep);
    chk("model_level", Level_Out, el);
    chk("model_flag", Event_Flag, ef);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    tick(3);
    chk("reset_pulse", Pulse_Signal, '0);
    chk("reset_level", Level_Out, '0);
    chk("reset_flag", Event_Flag, '0);
    Reset_N = 1'b1;
    Edge_Mode = 8'b10_01_11_01;
    tick(2);
    // ch0 rising edge: level after k+4, pulse k+5..k+7
    Signal_In[0] = 1'b1;
    tick(4);
    chk("t1_level_early", Level_Out & 4'b0001, 4'b0000);
    tick(1);
    chk("t1_level", Level_Out & 4'b0001, 4'b0001);
    chk("t1_pulse_early", Pulse_Signal & 4'b0001, 4'b0000);
    tick(1);
    chk("t1_pulse", Pulse_Signal & 4'b0001, 4'b0001);
    chk("t1_flag", Event_Flag & 4'b0001, 4'b0001);
    tick(2);
    chk("t1_pulse_last", Pulse_Signal & 4'b0001, 4'b0001);
    tick(1);
    chk("t1_pulse_end", Pulse_Signal & 4'b0001, 4'b0000);
    Signal_In[0] = 1'b0;
    tick(6);
    chk("t1_fall_level", Level_Out & 4'b0001, 4'b0000);
    chk("t1_fall_nopulse", Pulse_Signal & 4'b0001, 4'b0000);
    // ch1 glitch shorter than D is filtered
    Signal_In[1] = 1'b1;
    tick(2);
    Signal_In[1] = 1'b0;
    tick(8);
    chk("t3_glitch_level", Level_Out & 4'b0010, 4'b0000);
    chk("t3_glitch_flag", Event_Flag & 4'b0010, 4'b0000);
    // ch1 both edges 3 cycles apart: pulse extended to 6 continuous cycles
    Signal_In[1] = 1'b1;
    tick(3);
    Signal_In[1] = 1'b0;
    tick(2);
    chk("t4_pulse_pre", Pulse_Signal & 4'b0010, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t4_pulse_ext", Pulse_Signal & 4'b0010, 4'b0010);
    end
    tick(1);
    chk("t4_pulse_end", Pulse_Signal & 4'b0010, 4'b0000);
    // ch2 clear coincident with qualified edge: set wins
    Signal_In[2] = 1'b1;
    tick(5);
    Event_Clear[2] = 1'b1;
    tick(1);
    chk("t5_set_wins", Event_Flag & 4'b0100, 4'b0100);
    tick(1);
    chk("t5_cleared", Event_Flag & 4'b0100, 4'b0000);
    Event_Clear[2] = 1'b0;
    // ch0 reset mid-pulse, input held high through reset
    Signal_In[0] = 1'b1;
    tick(6);
    chk("t6_pulse_before", Pulse_Signal & 4'b0001, 4'b0001);
    #3 Reset_N = 1'b0;
    #1;
    chk("t6_async_pulse", Pulse_Signal, '0);
    chk("t6_async_level", Level_Out, '0);
    chk("t6_async_flag", Event_Flag, '0);
    @(negedge CLK);
    Reset_N = 1'b1;
    tick(5);
    chk("t6_level_after", Level_Out & 4'b0001, 4'b0001);
    chk("t6_pulse_wait", Pulse_Signal & 4'b0001, 4'b0000);
    tick(1);
    chk("t6_pulse_after", Pulse_Signal & 4'b0001, 4'b0001);
    // randomized traffic
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(5) == 0) Signal_In[c] = ~Signal_In[c];
        if ($urandom_range(39) == 0) Edge_Mode[2*c+:2] = 2'($urandom_range(3));
        Event_Clear[c] = $urandom_range(9) == 0;
      end
      if ($urandom_range(299) == 0) begin
        #2 Reset_N = 1'b0;
        @(negedge CLK);
        Reset_N = 1'b1;
      end else begin
        tick(1);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
